page_line_scheduler: RTL
========================

Name: page_line_scheduler

Overview:
Frame-paced scheduler that shares the ruled notebook page between NUM_REQ text-line requesters.
- Arbitrates round-robin, at most one grant per video frame.
- Assigns the next free ruled row and publishes per-row valid/owner state plus the y origin of the next row, so the text-overlay instances know where to draw.
- All page-state updates occur at frame boundary, so the visible page never tears mid-frame.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
NUM_ROWS, 19, ruled rows on the page
BASE_Y, 77, y origin (top-left) of row 0 text
ROW_PITCH, 20, vertical distance between rows in pixels
OWN_W, 3, owner-id width; must be >= clog2(NUM_REQ)

Ports:
VGA_CLK_IN  in  1  pixel clock; sole clock
RST_IN  in  1  synchronous, active-high reset
i_frame_start  in  1  one-cycle pulse when sx==799 && sy==525 (last pixel of frame)
i_req  in  NUM_REQ  request vector; requester holds its bit high until granted
i_clear  in  1  single-cycle clear-page request; any cycle
o_gnt  out  NUM_REQ  one-hot grant, one-cycle pulse
o_gnt_row  out  5  row index assigned; valid only while o_gnt != 0
o_row_valid  out  NUM_ROWS  bit k = row k holds committed text
o_row_owner  out  NUM_ROWS*OWN_W  flattened owner id per row; row k at [k*OWN_W +: OWN_W]
o_next_y  out  10  BASE_Y + next_row*ROW_PITCH
o_full  out  1  all rows used

Behaviour:
- Reset values, taking effect on the edge where RST_IN is sampled high:
  - state=WAIT_FRAME, rr_ptr=0, next_row=0, pending_clear=0.
  - o_gnt=0, o_gnt_row=0, o_row_valid=0, o_row_owner=0, o_full=0, o_next_y=BASE_Y.
- State machine: WAIT_FRAME -> ARB -> GRANT -> WAIT_FRAME; WAIT_FRAME -> CLEAR -> WAIT_FRAME.
- i_clear sets sticky pending_clear in any state.
- WAIT_FRAME, on i_frame_start, evaluated in this order:
  - pending_clear: go to CLEAR.
  - else (|i_req) && !o_full: go to ARB.
  - else stay in WAIT_FRAME.
- i_frame_start in any other state is ignored; the FSM needs at most 2 cycles per frame.
- ARB (1 cycle):
  - Sample i_req.
  - Winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - No bit set (request dropped): return to WAIT_FRAME, no grant.
- GRANT (1 cycle):
  - o_gnt[w]=1 and o_gnt_row=next_row.
  - Set o_row_valid[next_row] and owner[next_row]=w.
  - next_row increments; rr_ptr=(w+1) mod NUM_REQ.
  - o_full=1 when the incremented next_row == NUM_ROWS.
  - Grant latency: exactly 2 cycles after the i_frame_start pulse.
- All registered outputs change on the same edge as the GRANT-cycle commit.
- CLEAR (1 cycle):
  - o_row_valid=0, next_row=0, o_full=0, pending_clear=0.
  - rr_ptr is kept; no grant in this frame.
- Clear has priority over requests. A clear arriving in ARB/GRANT is applied at the next frame.
- o_next_y:
  - Combinational from next_row; 10-bit unsigned, no overflow for defaults (max 77+18*20=437).
  - When o_full, holds BASE_Y+(NUM_ROWS-1)*ROW_PITCH.
- Full: requests are not granted and stay pending; o_full stays 1 until CLEAR.
- Reset mid-operation: any state returns to reset values on the next edge; a pending GRANT is not issued.

Optional Feature:
SCROLL_EN
- Defined, with o_full=1 and a request present:
  - FSM still goes ARB -> GRANT.
  - On GRANT, rows 1..NUM_ROWS-1 shift to rows 0..NUM_ROWS-2 (valid and owner).
  - New line is written to row NUM_ROWS-1; o_gnt_row=NUM_ROWS-1.
  - o_full stays 1.
- Undefined: full page refuses grants as above.

Decomposition:
- Package page_pkg holds:
  - Constants NUM_ROWS, ROW_PITCH, BASE_Y and the text x origin 335.
  - Frame constants H_TOTAL=800, V_TOTAL=526.
  - typedef row_idx_t (5 bits) and typedef enum sched_state_t {WAIT_FRAME, ARB, GRANT, CLEAR}.
- One sub-module, page_rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index and found flag.

Test Plan:
- Reset, hold i_req=2'b01, pulse i_frame_start -> o_gnt=01 two cycles later, o_gnt_row=0, o_row_valid[0]=1, o_next_y 77->97.
- Hold i_req=2'b11 over 4 frames -> grants alternate 01,10,01,10 on rows 0,1,2,3; owners 0,1,0,1.
- Grant 19 frames (no SCROLL_EN) -> o_full=1 after 19th grant, o_next_y=437; 20th frame gives no o_gnt, row bitmap unchanged.
- Pulse i_clear mid-frame with i_req held -> next frame: no grant, o_row_valid=0, o_full=0, o_next_y=77; following frame grants row 0.
- Assert RST_IN during ARB -> no o_gnt pulse; all outputs at reset values on the next edge.
- SCROLL_EN, full page, i_req=2'b10 -> o_gnt_row=18, owner[18]=1, old owner[1] appears at row 0, o_row_valid all ones.

Source files
------------

// File: rtl/page_pkg.sv
// Shared constants, row index type and scheduler state encoding for the ruled-page line scheduler.
// Frame and text-origin constants are provided here for the overlay instances that use the schedule.
package page_pkg;

  localparam int unsigned NUM_ROWS  = 19;
  localparam int unsigned ROW_PITCH = 20;
  localparam int unsigned BASE_Y    = 77;
  localparam int unsigned TEXT_X    = 335;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_TOTAL   = 526;

  typedef logic [4:0] row_idx_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ARB        = 2'd1,
    GRANT      = 2'd2,
    CLEAR      = 2'd3
  } sched_state_t;

  function automatic logic [9:0] row_y(input int unsigned row, input int unsigned base,
                                       input int unsigned pitch);
    return 10'(base + row * pitch);
  endfunction

endpackage

// File: rtl/page_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_rr_ptr, wrapping modulo NUM_REQ.
module page_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned OWN_W   = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [OWN_W-1:0]   i_rr_ptr,
  output logic [OWN_W-1:0]   o_winner,
  output logic               o_found
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [OWN_W-1:0]     w_off;
  logic [OWN_W:0]       w_sum;

  // Rotating a doubled copy puts the pointer position at bit 0.
  assign w_dbl = {i_req, i_req};
  assign w_rot = NUM_REQ'(w_dbl >> i_rr_ptr);

  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!o_found && w_rot[i]) begin
        o_found = 1'b1;
        w_off   = OWN_W'(i);
      end
    end
    w_sum = {1'b0, i_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (OWN_W + 1)'(NUM_REQ)) begin
      w_sum = w_sum - (OWN_W + 1)'(NUM_REQ);
    end
    o_winner = w_sum[OWN_W-1:0];
  end

endmodule

// File: rtl/page_line_scheduler.sv
// Frame-paced round-robin allocator of ruled page rows to text-line requesters.
// Optional SCROLL_EN: a full page scrolls up one row per grant instead of refusing grants.
module page_line_scheduler #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned NUM_ROWS  = page_pkg::NUM_ROWS,
  parameter int unsigned BASE_Y    = page_pkg::BASE_Y,
  parameter int unsigned ROW_PITCH = page_pkg::ROW_PITCH,
  parameter int unsigned OWN_W     = 3
) (
  input  logic                      VGA_CLK_IN,
  input  logic                      RST_IN,
  input  logic                      i_frame_start,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic                      i_clear,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [4:0]                o_gnt_row,
  output logic [NUM_ROWS-1:0]       o_row_valid,
  output logic [NUM_ROWS*OWN_W-1:0] o_row_owner,
  output logic [9:0]                o_next_y,
  output logic                      o_full
);

  import page_pkg::*;

  sched_state_t              r_state;
  logic [OWN_W-1:0]          r_rr_ptr;
  row_idx_t                  r_next_row;
  logic                      r_pending_clear;
  logic [NUM_REQ-1:0]        r_gnt;
  row_idx_t                  r_gnt_row;
  logic [NUM_ROWS-1:0]       r_row_valid;
  logic [NUM_ROWS*OWN_W-1:0] r_row_owner;
  logic                      r_full;

  logic [OWN_W-1:0] w_winner;
  logic             w_found;
  logic             w_scroll;
  logic             w_can_arb;
  row_idx_t         w_next_row_inc;
  logic [OWN_W-1:0] w_rr_next;

  page_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_pick (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

`ifdef SCROLL_EN
  assign w_scroll = r_full;
`else
  assign w_scroll = 1'b0;
`endif

  assign w_can_arb      = !r_full || w_scroll;
  assign w_next_row_inc = r_next_row + row_idx_t'(1);
  assign w_rr_next      = (w_winner == OWN_W'(NUM_REQ - 1)) ? '0 : w_winner + OWN_W'(1);

  always_ff @(posedge VGA_CLK_IN) begin
    if (RST_IN) begin
      r_state         <= WAIT_FRAME;
      r_rr_ptr        <= '0;
      r_next_row      <= '0;
      r_pending_clear <= 1'b0;
      r_gnt           <= '0;
      r_gnt_row       <= '0;
      r_row_valid     <= '0;
      r_row_owner     <= '0;
      r_full          <= 1'b0;
    end else begin
      r_gnt <= '0;
      if (i_clear) begin
        r_pending_clear <= 1'b1;
      end
      case (r_state)
        WAIT_FRAME: begin
          if (i_frame_start) begin
            if (r_pending_clear) begin
              r_state         <= CLEAR;
              r_row_valid     <= '0;
              r_next_row      <= '0;
              r_full          <= 1'b0;
              // A clear landing on this very edge stays pending for the next frame.
              r_pending_clear <= i_clear;
            end else if ((|i_req) && w_can_arb) begin
              r_state <= ARB;
            end
          end
        end
        ARB: begin
          if (w_found) begin
            // Commit on entry to GRANT so every output moves together with the grant pulse.
            r_state  <= GRANT;
            r_gnt    <= NUM_REQ'(1) << w_winner;
            r_rr_ptr <= w_rr_next;
            if (w_scroll) begin
              r_row_valid <= {1'b1, r_row_valid[NUM_ROWS-1:1]};
              r_row_owner <= {w_winner, r_row_owner[NUM_ROWS*OWN_W-1:OWN_W]};
              r_gnt_row   <= row_idx_t'(NUM_ROWS - 1);
            end else begin
              for (int k = 0; k < int'(NUM_ROWS); k++) begin
                if (r_next_row == row_idx_t'(k)) begin
                  r_row_valid[k]                 <= 1'b1;
                  r_row_owner[k*OWN_W +: OWN_W] <= w_winner;
                end
              end
              r_gnt_row  <= r_next_row;
              r_next_row <= w_next_row_inc;
              r_full     <= (w_next_row_inc == row_idx_t'(NUM_ROWS));
            end
          end else begin
            r_state <= WAIT_FRAME;
          end
        end
        GRANT:   r_state <= WAIT_FRAME;
        CLEAR:   r_state <= WAIT_FRAME;
        default: r_state <= WAIT_FRAME;
      endcase
    end
  end

  // A full page points at its last row rather than one past the bottom.
  always_comb begin
    if (r_full) begin
      o_next_y = row_y(NUM_ROWS - 1, BASE_Y, ROW_PITCH);
    end else begin
      o_next_y = row_y(32'(r_next_row), BASE_Y, ROW_PITCH);
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_row   = r_gnt_row;
  assign o_row_valid = r_row_valid;
  assign o_row_owner = r_row_owner;
  assign o_full      = r_full;

endmodule
